// File: rtl/cart_control_mc.sv
// cart_control_mc: cart control register block with debug DMA channels,
// a masked W1C interrupt and a stalling debug FIFO read window.
// Optional feature macro: CART_CONTROL_DMA_AUTOINC_EN (DMA address advances
// by the transfer length when a channel's busy line falls).
module cart_control_mc #(
  parameter logic [7:0] VERSION      = 8'h62,
  parameter int         NUM_DMA      = 2,
  parameter int         FIFO_ITEMS_W = 11,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_n64_reset,
  input  logic                      i_n64_nmi,
  input  logic                      i_request,
  input  logic                      i_write,
  input  logic [10:0]               i_address,
  input  logic [31:0]               i_data,
  output logic                      o_busy,
  output logic                      o_ack,
  output logic [31:0]               o_data,
  output logic [9:0]                o_config,
  output logic                      o_n64_reset_btn,
  output logic [23:0]               o_ddipl_address,
  output logic [23:0]               o_sram_address,
  output logic [NUM_DMA-1:0]        o_dma_start,
  input  logic [NUM_DMA-1:0]        i_dma_busy,
  output logic [4*NUM_DMA-1:0]      o_dma_bank,
  output logic [24*NUM_DMA-1:0]     o_dma_address,
  output logic [20*NUM_DMA-1:0]     o_dma_length,
  output logic                      o_fifo_request,
  output logic                      o_fifo_flush,
  input  logic [FIFO_ITEMS_W-1:0]   i_fifo_items,
  input  logic [31:0]               i_fifo_data,
  output logic                      o_irq
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIFO_REQ = 2'd1, S_FIFO_WAIT = 2'd2} state_t;

  state_t                  r_state, w_next;
  logic                    w_busy, w_fifo_req;
  logic [SYNC_STAGES-1:0]  r_rst_chain, r_nmi_chain;
  logic                    r_rst_prev, r_nmi_prev;
  logic                    w_reset_sync, w_nmi_sync, w_hold;
  logic [9:0]              r_config;
  logic [15:0]             r_boot;
  logic                    r_btn;
  logic [23:0]             r_ddipl, r_sram;
  logic [6:0]              r_status, r_mask, w_set, w_clr;
  logic                    r_irq, r_ack, r_flush;
  logic [31:0]             r_data, w_rdata;
  logic [NUM_DMA-1:0]      r_dma_start, r_busy_prev;
  logic [4*NUM_DMA-1:0]    r_bank;
  logic [24*NUM_DMA-1:0]   r_addr;
  logic [20*NUM_DMA-1:0]   r_len;
  logic                    w_accept, w_fifo_win, w_fifo_pop, w_underflow, w_reg_wr;
  logic [5:0]              w_idx;
  logic                    w_unused;

  assign w_accept     = i_request && (r_state == S_IDLE);
  assign w_fifo_win   = i_address[10];
  assign w_fifo_pop   = w_accept && !i_write && w_fifo_win && (i_fifo_items != '0);
  assign w_underflow  = w_accept && !i_write && w_fifo_win && (i_fifo_items == '0);
  assign w_reg_wr     = w_accept && i_write && !w_fifo_win;
  assign w_idx        = i_address[5:0];
  assign w_reset_sync = r_rst_chain[SYNC_STAGES-1];
  assign w_nmi_sync   = r_nmi_chain[SYNC_STAGES-1];
  assign w_hold       = !w_reset_sync || !w_nmi_sync;
  assign w_unused     = ^{i_address, i_data};

  assign o_busy          = w_busy;
  assign o_fifo_request  = w_fifo_req;
  assign o_ack           = r_ack;
  assign o_data          = r_data;
  assign o_config        = r_config;
  assign o_n64_reset_btn = r_btn;
  assign o_ddipl_address = r_ddipl;
  assign o_sram_address  = r_sram;
  assign o_dma_start     = r_dma_start;
  assign o_dma_bank      = r_bank;
  assign o_dma_address   = r_addr;
  assign o_dma_length    = r_len;
  assign o_fifo_flush    = r_flush;
  assign o_irq           = r_irq;

  // Bus FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Bus FSM next state: only a non-empty FIFO-window read leaves IDLE.
  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b0;
    w_fifo_req = 1'b0;
    case (r_state)
      S_IDLE:      if (w_fifo_pop) w_next = S_FIFO_REQ;
      S_FIFO_REQ:  begin w_busy = 1'b1; w_fifo_req = 1'b1; w_next = S_FIFO_WAIT; end
      S_FIFO_WAIT: begin w_busy = 1'b1; w_next = S_IDLE; end
      default:     w_next = S_IDLE;
    endcase
  end

  // Synchronise the N64 reset/NMI lines and remember last value for edge detect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rst_chain <= '1;
      r_nmi_chain <= '1;
      r_rst_prev  <= 1'b1;
      r_nmi_prev  <= 1'b1;
      r_busy_prev <= '0;
    end else begin
      r_rst_chain <= {r_rst_chain[SYNC_STAGES-2:0], i_n64_reset};
      r_nmi_chain <= {r_nmi_chain[SYNC_STAGES-2:0], i_n64_nmi};
      r_rst_prev  <= w_reset_sync;
      r_nmi_prev  <= w_nmi_sync;
      r_busy_prev <= i_dma_busy;
    end
  end

  // Interrupt sources (falling edges, underflow) and W1C clear mask.
  always_comb begin
    w_set    = '0;
    w_set[0] = r_rst_prev && !w_reset_sync;
    w_set[1] = r_nmi_prev && !w_nmi_sync;
    for (int k = 0; k < NUM_DMA; k++) w_set[2+k] = r_busy_prev[k] && !i_dma_busy[k];
    w_set[6] = w_underflow;
    w_clr    = (w_reg_wr && w_idx == 6'd4) ? i_data[6:0] : 7'd0;
  end

  // Register read multiplexer.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      6'd0:    w_rdata = {22'd0, r_config};
      6'd1:    w_rdata = {16'd0, r_boot};
      6'd2:    w_rdata = {8'h53, 8'h36, 8'h34, VERSION};
      6'd3:    w_rdata = {29'd0, w_nmi_sync, w_reset_sync, !r_btn};
      6'd4:    w_rdata = {25'd0, r_status};
      6'd5:    w_rdata = {25'd0, r_mask};
      6'd6:    w_rdata = {6'd0, r_ddipl, 2'd0};
      6'd7:    w_rdata = {6'd0, r_sram, 2'd0};
      default: w_rdata = 32'd0;
    endcase
    for (int k = 0; k < NUM_DMA; k++) begin
      if (int'(w_idx) == 8 + 3*k)  w_rdata = {31'd0, i_dma_busy[k]};
      if (int'(w_idx) == 9 + 3*k)  w_rdata = {r_bank[4*k +: 4], 2'd0, r_addr[24*k +: 24], 2'd0};
      if (int'(w_idx) == 10 + 3*k) w_rdata = {12'd0, r_len[20*k +: 20]};
    end
  end

  // Register file, bus response, DMA control, interrupt and N64 hold override.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_config    <= '0;
      r_boot      <= '0;
      r_btn       <= 1'b1;
      r_ddipl     <= 24'hF0_0000;
      r_sram      <= 24'hFF_E000;
      r_status    <= '0;
      r_mask      <= '0;
      r_irq       <= 1'b0;
      r_ack       <= 1'b0;
      r_data      <= '0;
      r_flush     <= 1'b0;
      r_dma_start <= '0;
      r_bank      <= {NUM_DMA{4'h1}};
      r_addr      <= {NUM_DMA{24'hFC_0000}};
      r_len       <= '0;
    end else begin
      r_ack       <= 1'b0;
      r_dma_start <= '0;
      r_flush     <= w_hold || (w_reg_wr && w_idx == 6'd3 && i_data[1]);
      r_status    <= (r_status & ~w_clr) | w_set;
      r_irq       <= |(r_status & r_mask);
      if (w_accept && !w_fifo_pop) begin
        r_ack  <= 1'b1;
        r_data <= (!i_write && !w_fifo_win) ? w_rdata : 32'd0;
      end
      if (r_state == S_FIFO_WAIT) begin
        r_ack  <= 1'b1;
        r_data <= i_fifo_data;
      end
      if (w_reg_wr) begin
        case (w_idx)
          6'd0:    r_config <= i_data[9:0];
          6'd1:    r_boot   <= i_data[15:0];
          6'd3:    r_btn    <= !i_data[0];
          6'd5:    r_mask   <= i_data[6:0];
          6'd6:    r_ddipl  <= i_data[25:2];
          6'd7:    r_sram   <= i_data[25:2];
          default: ;
        endcase
      end
      for (int k = 0; k < NUM_DMA; k++) begin
        if (w_reg_wr && int'(w_idx) == 8 + 3*k && i_data[0] && !i_dma_busy[k])
          r_dma_start[k] <= 1'b1;
        if (w_reg_wr && int'(w_idx) == 9 + 3*k) begin
          r_bank[4*k +: 4]   <= i_data[31:28];
          r_addr[24*k +: 24] <= i_data[25:2];
        end
`ifdef CART_CONTROL_DMA_AUTOINC_EN
        else if (r_busy_prev[k] && !i_dma_busy[k])
          r_addr[24*k +: 24] <= r_addr[24*k +: 24] + {6'd0, r_len[20*k+2 +: 18]};
`endif
        if (w_reg_wr && int'(w_idx) == 10 + 3*k)
          r_len[20*k +: 20] <= i_data[19:0];
      end
      // N64 in reset/NMI: force safe cart state regardless of bus writes.
      if (w_hold) begin
        r_config[1:0] <= 2'b00;
        r_btn         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_control_mc.sv
// Directed testbench for cart_control_mc.
module tb_cart_control_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_n64_reset = 1'b1, i_n64_nmi = 1'b1;
  logic        i_request = 1'b0, i_write = 1'b0;
  logic [10:0] i_address = '0;
  logic [31:0] i_data = '0;
  logic        o_busy, o_ack;
  logic [31:0] o_data;
  logic [9:0]  o_config;
  logic        o_n64_reset_btn;
  logic [23:0] o_ddipl_address, o_sram_address;
  logic [1:0]  o_dma_start;
  logic [1:0]  i_dma_busy = '0;
  logic [7:0]  o_dma_bank;
  logic [47:0] o_dma_address;
  logic [39:0] o_dma_length;
  logic        o_fifo_request, o_fifo_flush;
  logic [10:0] i_fifo_items = '0;
  logic [31:0] i_fifo_data = '0;
  logic        o_irq;

  int errors = 0;
  int checks = 0;

  cart_control_mc #(.VERSION(8'h62), .NUM_DMA(2), .FIFO_ITEMS_W(11), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_n64_reset(i_n64_reset), .i_n64_nmi(i_n64_nmi),
    .i_request(i_request), .i_write(i_write), .i_address(i_address), .i_data(i_data),
    .o_busy(o_busy), .o_ack(o_ack), .o_data(o_data), .o_config(o_config),
    .o_n64_reset_btn(o_n64_reset_btn), .o_ddipl_address(o_ddipl_address),
    .o_sram_address(o_sram_address), .o_dma_start(o_dma_start), .i_dma_busy(i_dma_busy),
    .o_dma_bank(o_dma_bank), .o_dma_address(o_dma_address), .o_dma_length(o_dma_length),
    .o_fifo_request(o_fifo_request), .o_fifo_flush(o_fifo_flush),
    .i_fifo_items(i_fifo_items), .i_fifo_data(i_fifo_data), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One bus transfer; returns ack latency (0 = no ack within budget), busy and pop counts.
  task automatic bus_xfer(input logic wr, input logic [10:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int nbusy, output int npop);
    i_request = 1'b1; i_write = wr; i_address = a; i_data = d;
    @(posedge clk); #1;
    i_request = 1'b0;
    lat = 0; nbusy = 0; npop = 0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      if (o_busy) nbusy++;
      if (o_fifo_request) npop++;
      if (o_ack) begin
        lat = c; rd = o_data;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++; if (o_config !== 10'h000) begin errors++; $display("FAIL reset_config got %h want 000", o_config); end
    checks++; if (o_n64_reset_btn !== 1'b1) begin errors++; $display("FAIL reset_btn got %b want 1", o_n64_reset_btn); end
    checks++; if (o_ddipl_address !== 24'hF00000) begin errors++; $display("FAIL reset_ddipl got %h want F00000", o_ddipl_address); end
    checks++; if (o_sram_address !== 24'hFFE000) begin errors++; $display("FAIL reset_sram got %h want FFE000", o_sram_address); end
    checks++; if (o_dma_bank !== 8'h11) begin errors++; $display("FAIL reset_bank got %h want 11", o_dma_bank); end
    checks++; if (o_dma_address !== 48'hFC0000FC0000) begin errors++; $display("FAIL reset_dma_addr got %h want FC0000FC0000", o_dma_address); end
    checks++; if (o_dma_length !== 40'h0) begin errors++; $display("FAIL reset_dma_len got %h want 0", o_dma_length); end
    checks++; if ({o_dma_start, o_irq, o_ack, o_busy, o_fifo_request} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {o_dma_start, o_irq, o_ack, o_busy, o_fifo_request}); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_regs();
    logic [31:0] rd; int lat, nb, np;
    bus_xfer(1'b0, 11'd2, 32'h0, rd, lat, nb, np);
    checks++; if (lat !== 1) begin errors++; $display("FAIL version_lat got %0d want 1", lat); end
    checks++; if (rd !== 32'h53363462) begin errors++; $display("FAIL version got %h want 53363462", rd); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL reg_busy got %0d want 0", nb); end
    bus_xfer(1'b0, 11'd7, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h03FF8000) begin errors++; $display("FAIL sram_rd got %h want 03FF8000", rd); end
    bus_xfer(1'b1, 11'd1, 32'h1234ABCD, rd, lat, nb, np);
    bus_xfer(1'b0, 11'd1, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL boot_rd got %h want 0000ABCD", rd); end
    bus_xfer(1'b0, 11'd20, 32'h0, rd, lat, nb, np);
    checks++; if ({lat[3:0], rd} !== {4'd1, 32'h0}) begin errors++; $display("FAIL unmapped got lat %0d data %h want lat 1 data 0", lat, rd); end
  endtask

  task automatic test_back_to_back();
    i_request = 1'b1; i_write = 1'b0; i_address = 11'd2;
    @(posedge clk); #1;
    checks++; if ({o_ack, o_data} !== {1'b1, 32'h53363462}) begin errors++; $display("FAIL b2b_first got %b %h want 1 53363462", o_ack, o_data); end
    i_address = 11'd6;
    @(posedge clk); #1;
    checks++; if ({o_ack, o_data} !== {1'b1, 32'h03C00000}) begin errors++; $display("FAIL b2b_second got %b %h want 1 03C00000", o_ack, o_data); end
    i_request = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack got %b want 0", o_ack); end
  endtask

  task automatic test_fifo();
    logic [31:0] rd; int lat, nb, np;
    i_fifo_items = 11'd5; i_fifo_data = 32'hDEADBEEF;
    bus_xfer(1'b0, 11'h400, 32'h0, rd, lat, nb, np);
    checks++; if (lat !== 3) begin errors++; $display("FAIL fifo_lat got %0d want 3", lat); end
    checks++; if (nb !== 2) begin errors++; $display("FAIL fifo_busy got %0d want 2", nb); end
    checks++; if (np !== 1) begin errors++; $display("FAIL fifo_pops got %0d want 1", np); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fifo_data got %h want DEADBEEF", rd); end
    bus_xfer(1'b1, 11'h400, 32'h5, rd, lat, nb, np);
    checks++; if ({lat[3:0], np[3:0]} !== {4'd1, 4'd0}) begin errors++; $display("FAIL fifo_write got lat %0d pops %0d want 1 0", lat, np); end
  endtask

  task automatic test_underflow();
    logic [31:0] rd; int lat, nb, np;
    i_fifo_items = 11'd0;
    bus_xfer(1'b0, 11'h400, 32'h0, rd, lat, nb, np);
    checks++; if ({lat[3:0], np[3:0], rd} !== {4'd1, 4'd0, 32'h0}) begin errors++; $display("FAIL underflow got lat %0d pops %0d data %h want 1 0 0", lat, np, rd); end
    bus_xfer(1'b0, 11'd4, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h40) begin errors++; $display("FAIL underflow_status got %h want 40", rd); end
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", o_irq); end
    bus_xfer(1'b1, 11'd5, 32'h40, rd, lat, nb, np);
    step(1);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked got %b want 1", o_irq); end
    bus_xfer(1'b1, 11'd4, 32'h40, rd, lat, nb, np);
    step(1);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", o_irq); end
    bus_xfer(1'b1, 11'd5, 32'h0, rd, lat, nb, np);
  endtask

  task automatic test_dma();
    logic [31:0] rd; int lat, nb, np;
    logic [23:0] exp_addr;
`ifdef CART_CONTROL_DMA_AUTOINC_EN
    exp_addr = 24'h000140;
`else
    exp_addr = 24'h000040;
`endif
    bus_xfer(1'b1, 11'd12, 32'h10000100, rd, lat, nb, np);
    bus_xfer(1'b1, 11'd13, 32'h00000400, rd, lat, nb, np);
    checks++; if ({o_dma_bank[7:4], o_dma_address[47:24]} !== {4'h1, 24'h000040}) begin errors++; $display("FAIL dma1_addr got %h %h want 1 000040", o_dma_bank[7:4], o_dma_address[47:24]); end
    bus_xfer(1'b1, 11'd11, 32'h1, rd, lat, nb, np);
    checks++; if ({o_dma_length[39:20], o_dma_start} !== {20'h00400, 2'b10}) begin errors++; $display("FAIL dma1_start got len %h start %b want 00400 10", o_dma_length[39:20], o_dma_start); end
    step(1);
    checks++; if (o_dma_start !== 2'b00) begin errors++; $display("FAIL dma1_start_pulse got %b want 00", o_dma_start); end
    i_dma_busy = 2'b10;
    step(2);
    i_dma_busy = 2'b00;
    step(1);
    bus_xfer(1'b0, 11'd4, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL dma1_status got %h want 08", rd); end
    bus_xfer(1'b0, 11'd12, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== {4'h1, 2'b00, exp_addr, 2'b00}) begin errors++; $display("FAIL dma1_addr_after got %h want %h", rd, {4'h1, 2'b00, exp_addr, 2'b00}); end
  endtask

  task automatic test_busy_start();
    logic [31:0] rd; int lat, nb, np;
    i_dma_busy = 2'b01;
    step(1);
    bus_xfer(1'b1, 11'd8, 32'h1, rd, lat, nb, np);
    checks++; if (o_dma_start !== 2'b00) begin errors++; $display("FAIL busy_start got %b want 00", o_dma_start); end
    step(1);
    checks++; if (o_dma_start !== 2'b00) begin errors++; $display("FAIL busy_start_late got %b want 00", o_dma_start); end
    i_dma_busy = 2'b00;
    step(1);
  endtask

  task automatic test_nmi_hold();
    logic [31:0] rd; int lat, nb, np;
    bus_xfer(1'b1, 11'd4, 32'h7F, rd, lat, nb, np);
    bus_xfer(1'b1, 11'd0, 32'h3FF, rd, lat, nb, np);
    bus_xfer(1'b1, 11'd3, 32'h1, rd, lat, nb, np);
    checks++; if ({o_config, o_n64_reset_btn} !== {10'h3FF, 1'b0}) begin errors++; $display("FAIL scr_gpio got %h %b want 3FF 0", o_config, o_n64_reset_btn); end
    bus_xfer(1'b0, 11'd3, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL gpio_rd got %h want 7", rd); end
    i_n64_nmi = 1'b0;
    step(3);
    checks++; if ({o_config, o_n64_reset_btn, o_fifo_flush} !== {10'h3FC, 1'b1, 1'b1}) begin errors++; $display("FAIL nmi_hold got %h %b %b want 3FC 1 1", o_config, o_n64_reset_btn, o_fifo_flush); end
    step(1);
    i_n64_nmi = 1'b1;
    checks++; if (o_fifo_flush !== 1'b1) begin errors++; $display("FAIL nmi_flush2 got %b want 1", o_fifo_flush); end
    step(5);
    checks++; if (o_fifo_flush !== 1'b0) begin errors++; $display("FAIL nmi_flush_end got %b want 0", o_fifo_flush); end
    bus_xfer(1'b0, 11'd4, 32'h0, rd, lat, nb, np);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL nmi_status got %h want 02", rd); end
  endtask

  task automatic test_async_reset();
    i_fifo_items = 11'd5;
    i_request = 1'b1; i_write = 1'b0; i_address = 11'h400;
    @(posedge clk); #1;
    i_request = 1'b0;
    checks++; if ({o_busy, o_fifo_request} !== 2'b11) begin errors++; $display("FAIL ar_fifo_req got %b want 11", {o_busy, o_fifo_request}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_busy, o_fifo_request, o_ack, o_irq} !== 4'b0000) begin errors++; $display("FAIL ar_ctrl got %b want 0000", {o_busy, o_fifo_request, o_ack, o_irq}); end
    checks++; if ({o_config, o_n64_reset_btn, o_data} !== {10'h0, 1'b1, 32'h0}) begin errors++; $display("FAIL ar_regs got %h %b %h want 0 1 0", o_config, o_n64_reset_btn, o_data); end
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL ar_no_ack cycle %0d got %b want 0", c, o_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_back_to_back();
    test_fifo();
    test_underflow();
    test_dma();
    test_busy_start();
    test_nmi_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cart_control_mc.md
Name: cart_control_mc

Overview:
- Parametrised successor of the cart control register block. Cart config flags, boot word, version, GPIO, DD IPL / SRAM base addresses.
- Adds NUM_DMA debug DMA channels, a masked interrupt with W1C status, and a stalling read path for the debug FIFO window.
- Sits between the CPU bus bridge and the cart peripherals (SDRAM mux, save backends, USB debug DMA/FIFO).

Parameters:
VERSION, 8'h62 ("b"), low byte of version word {"S","6","4",VERSION}
NUM_DMA, 2, debug DMA channel count, legal 1..4
FIFO_ITEMS_W, 11, width of FIFO fill count
SYNC_STAGES, 2, synchroniser depth for i_n64_reset/i_n64_nmi, min 2

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low
i_n64_reset  in  1  N64 reset line, async, active-low
i_n64_nmi  in  1  N64 NMI line, async, active-low
i_request  in  1  bus request, sampled when !o_busy
i_write  in  1  1=write, 0=read
i_address  in  11  word address; <0x400 registers (bits[5:0] decode), >=0x400 FIFO window
i_data  in  32  write data
o_busy  out  1  bus stall
o_ack  out  1  one-cycle pulse, read or write complete
o_data  out  32  read data, valid with o_ack
o_config  out  10  {flashram_en, sram_768k, sram_en, sd_en, eeprom_pi_en, eeprom_16k, eeprom_en, ddipl_en, rom_switch, sdram_writable}
o_n64_reset_btn  out  1  reset button, active-low
o_ddipl_address  out  24  DD IPL word base
o_sram_address  out  24  SRAM word base
o_dma_start  out  NUM_DMA  per-channel one-cycle start pulse
i_dma_busy  in  NUM_DMA  per-channel busy
o_dma_bank  out  4*NUM_DMA  channel k at [4k+3:4k]
o_dma_address  out  24*NUM_DMA  channel k at [24k+23:24k]
o_dma_length  out  20*NUM_DMA  channel k bytes at [20k+19:20k]
o_fifo_request  out  1  one-cycle FIFO pop
o_fifo_flush  out  1  one-cycle FIFO flush
i_fifo_items  in  FIFO_ITEMS_W  FIFO fill
i_fifo_data  in  32  FIFO head; valid one cycle after o_fifo_request
o_irq  out  1  registered |(status & mask)

Behaviour:
- Reset values: o_config=0, o_n64_reset_btn=1, o_ddipl_address=F0_0000, o_sram_address=FF_E000, bank=1, address=FC_0000, length=0 (all channels), o_dma_start=0, status=0, mask=0, boot=0, o_irq=0, o_ack=0, o_busy=0, o_data=0, FSM=IDLE.
- Map: 0 SCR[9:0], 1 BOOT[15:0], 2 VERSION (RO), 3 GPIO (W:[0] reset btn pressed, [1] flush pulse; R:{nmi_sync,reset_sync,btn_pressed} in [2:0]), 4 IRQ_STATUS (W1C), 5 IRQ_MASK, 6 DDIPL_ADDR (data[25:2]), 7 SRAM_ADDR (data[25:2]), 8+3k DMA_SCR k (W:[0] start; R:[0] busy), 9+3k DMA_ADDR k ({bank,addr}={data[31:28],data[25:2]}), 10+3k DMA_LEN k ([19:0]). Unmapped/k>=NUM_DMA: writes ignored, reads 0, still acked.
- Register access, FSM IDLE: accept when i_request && !o_busy; o_ack next cycle; o_busy stays 0; back-to-back every cycle.
- FIFO-window read: IDLE -> FIFO_REQ (o_busy=1, o_fifo_request=1) -> FIFO_WAIT (o_busy=1, capture i_fifo_data) -> IDLE with o_ack. 3-cycle latency.
- If i_fifo_items==0 at accept: no o_fifo_request, o_data=0, ack next cycle, status[6] underflow set.
- FIFO-window writes: ignored, acked next cycle.
- Start write while i_dma_busy[k]=1: no pulse.
- Status bits: [0] reset_sync falling edge, [1] nmi_sync falling edge, [2+k] i_dma_busy[k] falling edge, [6] underflow. Same-cycle set and W1C: set wins. Mask write while pending: o_irq updates next cycle.
- While reset_sync==0 or nmi_sync==0: sdram_writable=0, rom_switch=0, o_n64_reset_btn=1, o_fifo_flush=1 each cycle. Overrides same-cycle bus writes to those bits. In-flight FIFO read completes normally.
- Async reset mid-FIFO read: FSM to IDLE, no ack.

Optional Feature:
- Macro CART_CONTROL_DMA_AUTOINC_EN.
- Defined: on channel k busy falling edge, address_k <= address_k + length_k[19:2], modulo 2^24, bank unchanged.
- Same-cycle bus write to DMA_ADDR k wins.
- Undefined: addresses change only by bus write.

Test Plan:
- Release reset, read reg 2 -> ack 1 cycle later, o_data=0x53363462; read reg 7 -> 0x03FF8000.
- i_fifo_items=5, i_fifo_data=0xDEADBEEF, read 0x400 -> busy 2 cycles, one o_fifo_request, ack cycle 3 with 0xDEADBEEF.
- i_fifo_items=0, read 0x400 -> no pop, ack next cycle, o_data=0, status=0x40. Mask 0x40 -> o_irq=1. W1C 0x40 -> o_irq=0.
- Channel 1: write DMA_ADDR 0x10000100, DMA_LEN 0x400, start -> o_dma_start[1] one cycle. busy 1->0 -> status[3]=1. AUTOINC_EN: address=0x000040+0x100=0x000140.
- SCR=0x3FF, GPIO=1, then i_n64_nmi low 4 cycles -> o_config=0x3FC, o_n64_reset_btn=1, flush high while low, status[1]=1.
- Start on busy channel 0 -> no o_dma_start[0]; async reset during FIFO_REQ -> no ack, all outputs to reset values.
